// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// stack_mem_ctrl: data-stack sequencer for the Forth CPU.
// Owns the stack pointer and drives a single-port, 1-cycle-read-latency stack RAM.
module stack_mem_ctrl #(
  parameter int DW    = 12,
  parameter int AW    = 12,
  parameter int BASE  = 75,
  parameter int LIMIT = 127
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          cmd_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  input  logic          rsp_ready,
  output logic          err_ovf,
  output logic          err_udf,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] depth,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0]    OP_PUSH = 2'b01;
  localparam logic [1:0]    OP_POP  = 2'b10;
  localparam logic [1:0]    OP_SET  = 2'b11;
  localparam logic [AW-1:0] BASE_A  = AW'(BASE);
  localparam logic [AW-1:0] LIMIT_A = AW'(LIMIT);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RDWAIT = 3'd3,
    RSP    = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] new_sp;
  logic          push_ok;
  logic          pop_ok;
  logic          set_ok;

  assign new_sp    = cmd_data[AW-1:0];
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign depth     = sp - BASE_A;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    push_ok  = (sp < LIMIT_A);
    pop_ok   = (sp > BASE_A);
    set_ok   = (new_sp >= BASE_A) && (new_sp <= LIMIT_A);
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_PUSH && push_ok)     state_nx = WR;
          else if (cmd_op == OP_POP && pop_ok)  state_nx = RD;
        end
      end
      WR:      state_nx = IDLE;
      RD:      state_nx = RDWAIT;
      RDWAIT:  state_nx = RSP;
      RSP:     if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // RAM strobes are registered at the accept edge so they are live during WR/RD;
  // address and write data simply hold outside those cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= BASE_A;
      rsp_data  <= '0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUSH: begin
                if (push_ok) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= sp;
                  mem_wdata <= cmd_data;
                end else begin
                  err_ovf <= 1'b1;
                end
              end
              OP_POP: begin
                if (pop_ok) begin
                  mem_re   <= 1'b1;
                  mem_addr <= sp - ONE_A;
                end else begin
                  err_udf <= 1'b1;
                end
              end
              OP_SET: begin
                if (set_ok) sp <= new_sp;
                else        err_ovf <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WR:      sp <= sp + ONE_A;
        RD:      sp <= sp - ONE_A;
        RDWAIT:  rsp_data <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_mem_ctrl.sv
`default_nettype none
// Bench for stack_mem_ctrl: timed transaction model plus directed vectors.
module tb_stack_mem_ctrl;

  localparam int DW = 12;
  localparam int AW = 12;
  localparam int BASE = 75;
  localparam int LIMIT = 127;
  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, SETP = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic          err_ovf;
  logic          err_udf;
  logic [AW-1:0] sp;
  logic [AW-1:0] depth;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  stack_mem_ctrl #(.DW(DW), .AW(AW), .BASE(BASE), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .err_ovf(err_ovf), .err_udf(err_udf), .sp(sp), .depth(depth),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Stack RAM with one-cycle read latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction model: stack contents by address, expected outputs per cycle.
  logic [DW-1:0] mstk [0:(1<<AW)-1];
  int            m_sp;
  logic          m_ready, m_rv, m_ovf, m_udf, m_we, m_re;
  logic [DW-1:0] m_rdata, m_wdata, pop_word;
  logic [AW-1:0] m_addr;
  logic          pend_push;
  int            pop_age;
  logic          acc;
  bit            started = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started = 1;
      m_sp = BASE; m_ready = 1; m_rv = 0; m_rdata = '0;
      m_ovf = 0; m_udf = 0; m_we = 0; m_re = 0; m_addr = '0; m_wdata = '0;
      pend_push = 0; pop_age = 0;
    end else if (started) begin
      acc = m_ready && cmd_valid;
      m_ovf = 0; m_udf = 0; m_we = 0; m_re = 0;
      if (pend_push) begin
        m_sp++; m_ready = 1; pend_push = 0;
      end
      if (pop_age == 1) begin
        m_sp--; pop_age = 2;
      end else if (pop_age == 2) begin
        m_rv = 1; m_rdata = pop_word; pop_age = 3;
      end else if (pop_age == 3 && rsp_ready) begin
        m_rv = 0; m_ready = 1; pop_age = 0;
      end
      if (acc) begin
        case (cmd_op)
          PUSH: if (m_sp == LIMIT) m_ovf = 1;
                else begin
                  m_we = 1; m_addr = AW'(m_sp); m_wdata = cmd_data;
                  mstk[m_sp] = cmd_data; pend_push = 1; m_ready = 0;
                end
          POP:  if (m_sp == BASE) m_udf = 1;
                else begin
                  m_re = 1; m_addr = AW'(m_sp - 1); pop_word = mstk[m_sp - 1];
                  pop_age = 1; m_ready = 0;
                end
          SETP: if (int'(cmd_data) >= BASE && int'(cmd_data) <= LIMIT) m_sp = int'(cmd_data);
                else m_ovf = 1;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmd_ready", cmd_ready, m_ready);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_data", rsp_data, m_rdata);
      check("err_ovf", err_ovf, m_ovf);
      check("err_udf", err_udf, m_udf);
      check("sp", sp, m_sp);
      check("depth", depth, m_sp - BASE);
      check("mem_we", mem_we, m_we);
      check("mem_re", mem_re, m_re);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Returns in the first cycle after the accept edge; acc_cyc holds that edge.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL send_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = NOP;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (!rsp_valid) begin
      total++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  int a0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sp", sp, 75);
    check("rst_depth", depth, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    // Pop on empty stack
    send(POP, '0);
    check("udf_pulse", err_udf, 1);
    check("udf_no_re", mem_re, 0);
    @(negedge clk);
    check("udf_once", err_udf, 0);
    check("udf_sp", sp, 75);

    // Two pushes
    send(PUSH, 12'hABC);
    check("push1_we", mem_we, 1);
    check("push1_addr", mem_addr, 75);
    check("push1_data", mem_wdata, 12'hABC);
    a0 = acc_cyc;
    send(PUSH, 12'h123);
    check("push2_addr", mem_addr, 76);
    check("push2_data", mem_wdata, 12'h123);
    check("push_spacing", acc_cyc - a0, 2);
    @(negedge clk);
    check("push_sp", sp, 77);
    check("push_depth", depth, 2);

    // Two pops, consumer always ready
    send(POP, '0);
    check("pop1_re", mem_re, 1);
    check("pop1_addr", mem_addr, 76);
    wait_rsp();
    check("pop1_latency", cyc + 1 - acc_cyc, 3);
    check("pop1_data", rsp_data, 12'h123);
    send(POP, '0);
    check("pop2_addr", mem_addr, 75);
    wait_rsp();
    check("pop2_latency", cyc + 1 - acc_cyc, 3);
    check("pop2_data", rsp_data, 12'hABC);
    @(negedge clk);
    check("pop_sp", sp, 75);

    // Backpressure with a push waiting behind the response
    send(PUSH, 12'h5A5);
    rsp_ready = 1'b0;
    send(POP, '0);
    wait_rsp();
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 12'h777;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 12'h5A5);
      check("bp_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    @(negedge clk);
    check("bp_push_we", mem_we, 1);
    check("bp_push_data", mem_wdata, 12'h777);
    cmd_valid = 1'b0; cmd_op = NOP;
    @(negedge clk);
    check("bp_sp", sp, 76);

    // Pointer range boundaries
    send(SETP, 12'd127);
    check("set127_sp", sp, 127);
    check("set127_ovf", err_ovf, 0);
    send(PUSH, 12'h111);
    check("full_ovf", err_ovf, 1);
    check("full_no_we", mem_we, 0);
    @(negedge clk);
    check("full_ovf_once", err_ovf, 0);
    send(SETP, 12'd200);
    check("set200_ovf", err_ovf, 1);
    check("set200_sp", sp, 127);
    send(SETP, 12'd74);
    check("set74_ovf", err_ovf, 1);
    check("set74_sp", sp, 127);
    send(SETP, 12'd75);
    check("set75_sp", sp, 75);

    // Reset during RDWAIT
    send(SETP, 12'd77);
    send(POP, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_sp", sp, 75);
    check("rstw_rv", rsp_valid, 0);
    repeat (4) @(negedge clk);
    check("rstw_no_stale", rsp_valid, 0);

    // Reset while a response is held
    send(PUSH, 12'h3C3);
    rsp_ready = 1'b0;
    send(POP, '0);
    wait_rsp();
    check("rsp_before_rst", rsp_data, 12'h3C3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("rstr_rv", rsp_valid, 0);
    check("rstr_sp", sp, 75);
    check("rstr_data", rsp_data, 0);
    repeat (4) @(negedge clk);
    check("rstr_no_stale", rsp_valid, 0);
    send(POP, '0);
    check("rstr_udf", err_udf, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
